// File: rtl/axi_arb_pkg.sv
// Shared types and the round-robin pick helper for the AXI buffer arbiter.
// The helper works on a fixed maximum width so any N_REQ up to MAX_REQ can reuse it.
package axi_arb_pkg;

    localparam int unsigned MAX_REQ      = 32;
    localparam int unsigned MAX_ID_W     = 5;
    localparam int unsigned CNT_W        = MAX_ID_W + 1;
    localparam int unsigned ARB_ID_RESET = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping at n_req.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input logic [CNT_W-1:0]    n_req
    );
        rr_pick_t         res;
        logic [CNT_W-1:0] pos;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            pos = CNT_W'(ptr) + CNT_W'(i);
            if (pos >= n_req) begin
                pos = pos - n_req;
            end
            if ((CNT_W'(i) < n_req) && !res.found && valid[pos[MAX_ID_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[MAX_ID_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_buffer_rr_arbiter_pick.sv
// Combinational rotate-and-find-first-one over N_REQ requesters.
module axi_rr_pick
    import axi_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  idx_c_o,
    output logic             found_c_o
);

    rr_pick_t pick;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(valid_i), MAX_ID_W'(ptr_i), CNT_W'(N_REQ));
        idx_c_o   = ID_W'(pick.idx);
        found_c_o = pick.found;
    end

endmodule

// File: rtl/axi_buffer_rr_arbiter.sv
// N-to-1 round-robin arbiter feeding one axi_buffer through a registered slot.
// Grant is held for a whole burst so beats of different sources never interleave.
module axi_buffer_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int unsigned N_REQ        = 4,
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  bit          LOCK_ON_LAST = 1'b1,
    localparam int unsigned LOG_N_REQ    = $clog2(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_last_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        last_o,
    output logic [LOG_N_REQ-1:0]        id_o,
    output logic                        valid_o,
    input  logic                        ready_i
);

    arb_state_t             state_q, state_d;
    logic [LOG_N_REQ-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LOG_N_REQ-1:0]   lock_id_q, lock_id_d;
    logic [LOG_N_REQ-1:0]   id_q, id_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   last_q, last_d;
    logic                   valid_q, valid_d;

    logic [N_REQ-1:0]       eligible;
    logic [LOG_N_REQ-1:0]   pick_ptr;
    logic [LOG_N_REQ-1:0]   win_id;
    logic                   found;
    logic                   can_accept;
    logic                   hs;
    logic [DATA_WIDTH-1:0]  win_data;
    logic                   win_last;

    function automatic logic [LOG_N_REQ-1:0] next_id(input logic [LOG_N_REQ-1:0] cur);
        if (cur == LOG_N_REQ'(N_REQ - 1)) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

    // While locked only the burst owner may win.
    always_comb begin
        eligible = req_valid_i;
        pick_ptr = rr_ptr_q;
        if (state_q == LOCKED) begin
            eligible = req_valid_i & (N_REQ'(1) << lock_id_q);
            pick_ptr = lock_id_q;
        end
    end

    axi_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .valid_i   (eligible),
        .ptr_i     (pick_ptr),
        .idx_c_o   (win_id),
        .found_c_o (found)
    );

    always_comb begin
        can_accept  = !valid_q || ready_i;
        hs          = found && can_accept;
        win_data    = req_data_i[win_id*DATA_WIDTH +: DATA_WIDTH];
        win_last    = req_last_i[win_id];

        req_ready_o = '0;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_id_d   = lock_id_q;
        valid_d     = valid_q;
        data_d      = data_q;
        last_d      = last_q;
        id_d        = id_q;

        if (hs) begin
            req_ready_o[win_id] = 1'b1;
        end

        // A new beat overwrites the slot even while it drains, so no bubble.
        if (hs) begin
            valid_d = 1'b1;
            data_d  = win_data;
            last_d  = win_last;
            id_d    = win_id;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (LOCK_ON_LAST && !win_last) begin
                        state_d   = LOCKED;
                        lock_id_d = win_id;
                    end else begin
                        rr_ptr_d = next_id(win_id);
                    end
                end
            end
            LOCKED: begin
                if (hs && win_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_id(lock_id_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lock_id_q <= LOG_N_REQ'(ARB_ID_RESET);
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            id_q      <= LOG_N_REQ'(ARB_ID_RESET);
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            id_q      <= id_d;
        end
    end

    assign data_o  = data_q;
    assign last_o  = last_q;
    assign id_o    = id_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_axi_buffer_rr_arbiter.sv
// Scoreboard bench: per-requester beat sources feed the arbiter, expected
// output beats are queued up front and a monitor pops them as the slot drains.
module tb_axi_buffer_rr_arbiter;

    logic         clk;
    logic         rst;
    logic         ready;
    logic         sel_b;
    logic [3:0]   src_valid;
    logic [3:0]   src_last;
    logic [127:0] src_data;
    logic [3:0]   a_req_valid, b_req_valid;
    logic [3:0]   a_ready, b_ready, cur_ready;
    logic [31:0]  a_data, b_data;
    logic         a_last, b_last, a_valid, b_valid;
    logic [1:0]   a_id, b_id;

    logic [32:0]  mem [4][32];
    int           wr [4];
    int           rd [4];
    int           grant_cnt [4];
    logic [34:0]  exp_a [$];
    logic [34:0]  exp_b [$];
    logic [34:0]  mon_e;
    logic         a_stall;
    logic [34:0]  a_stall_beat;
    int           checks;
    int           errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_req_valid = sel_b ? 4'b0 : src_valid;
    assign b_req_valid = sel_b ? src_valid : 4'b0;
    assign cur_ready   = sel_b ? b_ready : a_ready;

    axi_buffer_rr_arbiter #(.N_REQ(4), .DATA_WIDTH(32), .LOCK_ON_LAST(1'b1)) u_dut_lock (
        .clk_i(clk), .rst_i(rst), .req_valid_i(a_req_valid), .req_data_i(src_data),
        .req_last_i(src_last), .req_ready_o(a_ready), .data_o(a_data), .last_o(a_last),
        .id_o(a_id), .valid_o(a_valid), .ready_i(ready)
    );

    axi_buffer_rr_arbiter #(.N_REQ(4), .DATA_WIDTH(32), .LOCK_ON_LAST(1'b0)) u_dut_free (
        .clk_i(clk), .rst_i(rst), .req_valid_i(b_req_valid), .req_data_i(src_data),
        .req_last_i(src_last), .req_ready_o(b_ready), .data_o(b_data), .last_o(b_last),
        .id_o(b_id), .valid_o(b_valid), .ready_i(ready)
    );

    // Upstream sources must hold valid and data until accepted.
    for (genvar k = 0; k < 4; k++) begin : g_src_stable
        assert property (@(posedge clk) disable iff (rst)
            (src_valid[k] && !cur_ready[k]) |=> (src_valid[k] && $stable(src_data[k*32 +: 32])));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d, input logic l);
        mem[k][wr[k]] = {l, d};
        wr[k]++;
    endtask

    task automatic expa(input int id, input logic [31:0] d, input logic l);
        exp_a.push_back({2'(id), l, d});
    endtask

    task automatic expb(input int id, input logic [31:0] d, input logic l);
        exp_b.push_back({2'(id), l, d});
    endtask

    function automatic logic src_busy();
        logic busy;
        busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rd[k] < wr[k]) busy = 1'b1;
        end
        return busy;
    endfunction

    task automatic drive_src();
        for (int k = 0; k < 4; k++) begin
            if (rd[k] < wr[k]) begin
                src_valid[k]          = 1'b1;
                src_data[k*32 +: 32]  = mem[k][rd[k]][31:0];
                src_last[k]           = mem[k][rd[k]][32];
            end else begin
                src_valid[k]          = 1'b0;
                src_data[k*32 +: 32]  = '0;
                src_last[k]           = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes mid-cycle, advance sources after the edge.
    task automatic tick();
        logic [3:0] hs;
        @(negedge clk);
        hs = src_valid & cur_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) begin
                rd[k]++;
                grant_cnt[k]++;
            end
        end
        drive_src();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || src_busy()) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL %s_drain actual=timeout required=all_beats_out", name);
        end
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_stall && a_valid) begin
                check("a_stall_hold", 64'({a_id, a_last, a_data}), 64'(a_stall_beat));
            end
            if (a_valid && !ready) begin
                check("a_backpressure_ready", 64'(a_ready), 64'(0));
            end
            if (a_valid && ready) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_extra_beat actual=%0h required=none", {a_id, a_last, a_data});
                end else begin
                    mon_e = exp_a.pop_front();
                    check("a_beat", 64'({a_id, a_last, a_data}), 64'(mon_e));
                end
            end
            if (b_valid && ready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_extra_beat actual=%0h required=none", {b_id, b_last, b_data});
                end else begin
                    mon_e = exp_b.pop_front();
                    check("b_beat", 64'({b_id, b_last, b_data}), 64'(mon_e));
                end
            end
        end
        a_stall      = !rst && a_valid && !ready;
        a_stall_beat = {a_id, a_last, a_data};
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        a_stall  = 1'b0;
        sel_b    = 1'b0;
        rst      = 1'b1;
        ready    = 1'b0;
        src_data = '0;
        for (int k = 0; k < 4; k++) begin
            wr[k] = 0;
            rd[k] = 0;
            grant_cnt[k] = 0;
        end
        drive_src();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid_o", 64'(a_valid), 64'(0));
        check("rst_data_o", 64'(a_data), 64'(0));
        check("rst_last_o", 64'(a_last), 64'(0));
        check("rst_id_o", 64'(a_id), 64'(0));
        check("rst_req_ready", 64'(a_ready), 64'(0));
        check("rst_b_valid_o", 64'(b_valid), 64'(0));

        // Single beats from all four: ids rotate 0,1,2,3 back to back.
        ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                push(k, 32'(16 * (r + 1) + k), 1'b1);
                expa(k, 32'(16 * (r + 1) + k), 1'b1);
            end
        end
        drive_src();
        repeat (8) tick();
        check("rr_throughput_src_empty", 64'(src_busy()), 64'(0));
        for (int k = 0; k < 4; k++) begin
            check("rr_grants_per_req", 64'(grant_cnt[k]), 64'(2));
        end
        drain("rr");

        // Req1 burst held against req0/req2 competition.
        push(0, 32'h200, 1'b1);
        push(0, 32'h201, 1'b1);
        for (int i = 0; i < 4; i++) push(1, 32'h100 + 32'(i), (i == 3));
        push(2, 32'h300, 1'b1);
        expa(0, 32'h200, 1'b1);
        expa(1, 32'h100, 1'b0);
        expa(1, 32'h101, 1'b0);
        expa(1, 32'h102, 1'b0);
        expa(1, 32'h103, 1'b1);
        expa(2, 32'h300, 1'b1);
        expa(0, 32'h201, 1'b1);
        drive_src();
        drain("burst");

        // Req3 burst under backpressure.
        for (int i = 0; i < 4; i++) begin
            push(3, 32'hA0 + 32'(i), (i == 3));
            expa(3, 32'hA0 + 32'(i), (i == 3));
        end
        drive_src();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        tick();
        ready = 1'b1;
        drain("stall");

        // Pointer wrap from 3 to 0.
        push(2, 32'h42, 1'b1);
        expa(2, 32'h42, 1'b1);
        drive_src();
        drain("wrap_pre");
        push(3, 32'h43, 1'b1);
        push(0, 32'h40, 1'b1);
        expa(3, 32'h43, 1'b1);
        expa(0, 32'h40, 1'b1);
        drive_src();
        drain("wrap");
        for (int k = 0; k < 4; k++) push(k, 32'h50 + 32'(k), 1'b1);
        expa(1, 32'h51, 1'b1);
        expa(2, 32'h52, 1'b1);
        expa(3, 32'h53, 1'b1);
        expa(0, 32'h50, 1'b1);
        drive_src();
        drain("wrap_ptr");

        // Without locking, streaming sources alternate every beat.
        sel_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(0, 32'hC0 + 32'(i), 1'b0);
            push(1, 32'hD0 + 32'(i), 1'b0);
            expb(0, 32'hC0 + 32'(i), 1'b0);
            expb(1, 32'hD0 + 32'(i), 1'b0);
        end
        drive_src();
        drain("no_lock");
        sel_b = 1'b0;
        drive_src();

        // Reset during beat 2 of a req2 burst drops the slot and the lock.
        for (int i = 0; i < 4; i++) push(2, 32'hE0 + 32'(i), (i == 3));
        expa(2, 32'hE0, 1'b0);
        drive_src();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid_o", 64'(a_valid), 64'(0));
        push(1, 32'hF1, 1'b1);
        drive_src();
        #1;
        check("midrst_rearb_ready", 64'(a_ready), 64'(4'b0010));
        expa(1, 32'hF1, 1'b1);
        expa(2, 32'hE3, 1'b1);
        drain("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
